// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg : shared widths, default thresholds and helpers for sync_fifo_flagged
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sync_fifo_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_THRESH = 2;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int LEVEL_W = $clog2(DEF_DEPTH) + 1;

  typedef logic [LEVEL_W-1:0] level_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ---------------------------------------------------------------------------
// sync_fifo_ram : WIDTH x DEPTH simple dual-port array (macro SYNC_FIFO_FWFT_EN)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; the top keeps the stale copy.
  logic unused_ok;
  assign unused_ok = ^{rst, re};
  assign rdata     = mem[raddr];
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// sync_fifo_flagged : single-clock FIFO with level, threshold and sticky error flags
// Optional first-word-fall-through read via macro SYNC_FIFO_FWFT_EN.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       w_data,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       r_data,
  input  logic                   clear_err,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("sync_fifo_flagged: DEPTH must be a power of two and >= 4");
  end
  if ((AE_THRESH < 0) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_chk_thresh
    $error("sync_fifo_flagged: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (WIDTH < 1) begin : g_chk_width
    $error("sync_fifo_flagged: WIDTH must be >= 1");
  end

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  assign full         = (count == FULL_LVL);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign level        = count;

  // Requests coinciding with reset are dropped, including the memory write.
  assign wr_acc = w_en && !full && !rst;
  assign rd_acc = r_en && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A new error in the same cycle as clear_err leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)   overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (r_en && empty)  underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (w_data),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Keeps the last popped word so r_data is stale rather than garbage when empty.
  logic [WIDTH-1:0] hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
    end else if (rd_acc) begin
      hold <= ram_rdata;
    end
  end

  assign r_data = empty ? hold : ram_rdata;
`else
  assign r_data = ram_rdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flagged.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_flagged : directed + random bench against a queue reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_flagged;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             w_en = 1'b0;
  logic [WIDTH-1:0] w_data = '0;
  logic             r_en = 1'b0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] r_data;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]       level;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_rdata = '0;
  logic             m_ov = 1'b0;
  logic             m_un = 1'b0;

  sync_fifo_flagged #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .w_data       (w_data),
    .r_en         (r_en),
    .r_data       (r_data),
    .clear_err    (clear_err),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model one clock edge from the inputs presented before it.
  task automatic model_edge();
    logic was_full, was_empty, wa, ra;
    logic [WIDTH-1:0] popped;
    if (rst) begin
      q.delete();
      m_rdata = '0;
      m_ov    = 1'b0;
      m_un    = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      wa = w_en && !was_full;
      ra = r_en && !was_empty;
      if (ra) begin
        popped  = q.pop_front();
        m_rdata = popped;
      end
      if (wa) q.push_back(w_data);
      if (w_en && was_full) m_ov = 1'b1;
      else if (clear_err)   m_ov = 1'b0;
      if (r_en && was_empty) m_un = 1'b1;
      else if (clear_err)    m_un = 1'b0;
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_rdata();
`ifdef SYNC_FIFO_FWFT_EN
    return (q.size() > 0) ? q[0] : m_rdata;
`else
    return m_rdata;
`endif
  endfunction

  task automatic check_all();
    chk("level",        32'(level),        32'(q.size()));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("full",         32'(full),         32'(q.size() == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("r_data",       32'(r_data),       32'(exp_rdata()));
  endtask

  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                      input logic c, input logic rs);
    w_en = w; w_data = d; r_en = r; clear_err = c; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // Reset, then idle
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 0);
    chk("reset_level_zero", 32'(level), 32'd0);
    chk("reset_rdata_zero", 32'(r_data), 32'd0);

    // Fill to full, then overflow with 0xAA
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("full_at_16", 32'(full), 32'd1);
    step(1, 8'hAA, 0, 0, 0);
    chk("overflow_set", 32'(overflow), 32'd1);
    chk("level_held_16", 32'(level), 32'd16);

    // Drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("fwft_head", 32'(r_data), 32'(i));
`endif
      step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
      chk("drain_data", 32'(r_data), 32'(i));
`endif
    end
    chk("empty_after_drain", 32'(empty), 32'd1);
    step(0, 8'h00, 1, 0, 0);
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("rdata_unchanged", 32'(r_data), 32'h0F);

    // Clear errors
    step(0, 8'h00, 0, 1, 0);
    chk("ov_cleared", 32'(overflow), 32'd0);
    chk("un_cleared", 32'(underflow), 32'd0);

    // Wrap with concurrency at level 8
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(8'h48 + i), 1, 0, 0);
      chk("conc_level8", 32'(level), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    // Simultaneous read/write from empty
    step(1, 8'h77, 1, 0, 0);
    chk("empty_rw_level", 32'(level), 32'd1);
    chk("empty_rw_underflow", 32'(underflow), 32'd1);
    step(0, 8'h00, 1, 1, 0);

    // clear_err in same cycle as write-while-full
    for (int i = 0; i < 16; i++) step(1, 8'(8'h90 + i), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    chk("ov_set_wins", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1, 0);

    // Reset at level 9
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    chk("level9", 32'(level), 32'd9);
    step(1, 8'hFF, 1, 0, 1);
    chk("rst_level0", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("post_rst_data", 32'(r_data), 32'h55);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
